eu_icon_arbiter: RTL and testbench



---
 rtl/eu_icon_arbiter_pkg.sv | 18 +
 rtl/eu_icon_arbiter_pick.sv | 27 ++
 rtl/eu_icon_arbiter.sv | 148 ++++++++++++++
 tb/tb_eu_icon_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/eu_icon_arbiter_pkg.sv
// Shared types for the execution-unit interconnect channel allocator.
package exec_unit_dtypes;

  localparam int OWNER_W    = 8;
  localparam int HOLD_CNT_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } type_icon_arb_state;

  typedef struct packed {
    logic                  busy;
    logic [OWNER_W-1:0]    owner;
    logic [HOLD_CNT_W-1:0] hold_cnt;
  } type_icon_ch_alloc;

endpackage

// File: rtl/eu_icon_arbiter_pick.sv
// Round-robin first-set finder: first set bit of mask at or after start, wrapping.
module rr_pick_first #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  always_comb begin
    int u;
    found = 1'b0;
    idx   = '0;
    u     = 0;
    for (int i = 0; i < N; i++) begin
      u = int'(start) + i;
      if (u >= N) u = u - N;
      if (!found && mask[u]) begin
        found = 1'b1;
        idx   = W'(u);
      end
    end
  end

endmodule

// File: rtl/eu_icon_arbiter.sv
// Round-robin allocator of shared interconnect channels to execution units,
// with release on last/abandon and hold-timeout pre-emption.
module eu_icon_arbiter
  import exec_unit_dtypes::*;
#(
  parameter  int NUM_CHANNELS = 2,
  parameter  int NUM_UNITS    = 2,
  parameter  int MAX_HOLD     = 8,
  localparam int ARB_CH_WIDTH = $clog2(NUM_UNITS),
  localparam int CH_IDX_WIDTH = $clog2(NUM_CHANNELS),
  localparam int HOLD_W       = $clog2(MAX_HOLD + 1)
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_UNITS-1:0]                     req,
  input  logic [NUM_UNITS-1:0]                     last,
  output logic [NUM_UNITS-1:0]                     grant,
  output logic [NUM_UNITS-1:0][CH_IDX_WIDTH-1:0]   grant_ch,
  output logic [NUM_CHANNELS-1:0]                  ch_busy,
  output logic [NUM_CHANNELS-1:0][ARB_CH_WIDTH-1:0] ch_owner
);

  localparam logic [HOLD_W-1:0]     HOLD_MAX   = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_CNT_W-1:0] HOLD_LIMIT = HOLD_CNT_W'(HOLD_MAX);

  type_icon_arb_state st_q    [NUM_CHANNELS];
  type_icon_arb_state st_d    [NUM_CHANNELS];
  type_icon_ch_alloc  alloc_q [NUM_CHANNELS];
  type_icon_ch_alloc  alloc_d [NUM_CHANNELS];

  logic [ARB_CH_WIDTH-1:0]                    rr_ptr, rr_ptr_d;
  logic [NUM_UNITS-1:0]                       grant_d;
  logic [NUM_UNITS-1:0][CH_IDX_WIDTH-1:0]     grant_ch_d;
  logic [NUM_UNITS-1:0]                       waiting;
  logic [NUM_CHANNELS-1:0]                    rel, avail, pick_found;
  logic [NUM_CHANNELS-1:0][ARB_CH_WIDTH-1:0]  pick_idx;

  // A releasing channel is immediately available so hand-over has no idle cycle.
  always_comb begin
    waiting = req & ~grant;
    rel     = '0;
    avail   = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (st_q[c] == OWNED) begin
        for (int u = 0; u < NUM_UNITS; u++) begin
          if (alloc_q[c].owner == OWNER_W'(u))
            rel[c] = last[u] | ~req[u] |
                     ((alloc_q[c].hold_cnt == HOLD_LIMIT) & (|waiting));
        end
      end
      avail[c] = (st_q[c] == IDLE) | rel[c];
    end
  end

  // Pickers chained in ascending channel order; each removes its pick from the next mask.
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_pick
    logic [NUM_UNITS-1:0]    mask_in, mask_out, mask_use;
    logic                    found;
    logic [ARB_CH_WIDTH-1:0] idx;

    if (c == 0) begin : g_first
      assign mask_in = waiting;
    end else begin : g_next
      assign mask_in = g_pick[c-1].mask_out;
    end

    assign mask_use = avail[c] ? mask_in : '0;

    rr_pick_first #(.N(NUM_UNITS), .W(ARB_CH_WIDTH)) u_pick (
      .mask  (mask_use),
      .start (rr_ptr),
      .found (found),
      .idx   (idx)
    );

    assign mask_out      = found ? (mask_in & ~(NUM_UNITS'(1) << idx)) : mask_in;
    assign pick_found[c] = found;
    assign pick_idx[c]   = idx;
  end

  always_comb begin
    logic                    any_pick;
    logic [ARB_CH_WIDTH-1:0] last_pick;
    any_pick   = 1'b0;
    last_pick  = '0;
    grant_d    = '0;
    grant_ch_d = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      st_d[c]    = st_q[c];
      alloc_d[c] = alloc_q[c];
      if (pick_found[c]) begin
        st_d[c]             = OWNED;
        alloc_d[c].busy     = 1'b1;
        alloc_d[c].owner    = OWNER_W'(pick_idx[c]);
        alloc_d[c].hold_cnt = '0;
        any_pick            = 1'b1;
        last_pick           = pick_idx[c];
      end else if (rel[c]) begin
        st_d[c]    = IDLE;
        alloc_d[c] = '0;
      end else if ((st_q[c] == OWNED) && (|waiting) &&
                   (alloc_q[c].hold_cnt != HOLD_LIMIT)) begin
        alloc_d[c].hold_cnt = alloc_q[c].hold_cnt + 1'b1;
      end
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (alloc_d[c].busy && (alloc_d[c].owner == OWNER_W'(u))) begin
          grant_d[u]    = 1'b1;
          grant_ch_d[u] = CH_IDX_WIDTH'(c);
        end
      end
    end
    rr_ptr_d = rr_ptr;
    if (any_pick)
      rr_ptr_d = (last_pick == ARB_CH_WIDTH'(NUM_UNITS - 1)) ? '0 : last_pick + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        st_q[c]    <= IDLE;
        alloc_q[c] <= '0;
      end
      rr_ptr   <= '0;
      grant    <= '0;
      grant_ch <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        st_q[c]    <= st_d[c];
        alloc_q[c] <= alloc_d[c];
      end
      rr_ptr   <= rr_ptr_d;
      grant    <= grant_d;
      grant_ch <= grant_ch_d;
    end
  end

  always_comb begin
    ch_busy  = '0;
    ch_owner = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      ch_busy[c] = alloc_q[c].busy;
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (alloc_q[c].owner == OWNER_W'(u)) ch_owner[c] = ARB_CH_WIDTH'(u);
      end
    end
  end

endmodule

// File: tb/tb_eu_icon_arbiter.sv
// Directed bench for eu_icon_arbiter: queue-based allocation model plus literal checkpoints.
module tb_eu_icon_arbiter;

  localparam int NU  = 4;
  localparam int NC  = 2;
  localparam int MH  = 4;
  localparam int AW  = $clog2(NU);
  localparam int CW  = $clog2(NC);

  logic                   clk;
  logic                   reset;
  logic [NU-1:0]          req;
  logic [NU-1:0]          last;
  logic [NU-1:0]          grant;
  logic [NU-1:0][CW-1:0]  grant_ch;
  logic [NC-1:0]          ch_busy;
  logic [NC-1:0][AW-1:0]  ch_owner;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: owning unit per channel (-1 = free), hold counts, rr pointer.
  int m_owner [NC];
  int m_hold  [NC];
  int m_rr;

  eu_icon_arbiter #(.NUM_CHANNELS(NC), .NUM_UNITS(NU), .MAX_HOLD(MH)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .last     (last),
    .grant    (grant),
    .grant_ch (grant_ch),
    .ch_busy  (ch_busy),
    .ch_owner (ch_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit waiting [NU];
    int nwait;
    int q[$];
    int nown [NC];
    int nhold [NC];
    int nrr;
    int o;
    bit owned, rel;
    nwait = 0;
    for (int u = 0; u < NU; u++) begin
      owned = 0;
      for (int c = 0; c < NC; c++) if (m_owner[c] == u) owned = 1;
      waiting[u] = req[u] && !owned;
      if (waiting[u]) nwait++;
    end
    for (int k = 0; k < NU; k++) if (waiting[(m_rr + k) % NU]) q.push_back((m_rr + k) % NU);
    nrr = m_rr;
    for (int c = 0; c < NC; c++) begin
      o   = m_owner[c];
      rel = (o >= 0) && (last[o] || !req[o] || (m_hold[c] == MH && nwait > 0));
      if ((o < 0 || rel) && q.size() > 0) begin
        nown[c]  = q.pop_front();
        nhold[c] = 0;
        nrr      = (nown[c] + 1) % NU;
      end else if (rel) begin
        nown[c]  = -1;
        nhold[c] = 0;
      end else begin
        nown[c]  = o;
        nhold[c] = (o >= 0 && nwait > 0 && m_hold[c] < MH) ? m_hold[c] + 1 : m_hold[c];
      end
    end
    for (int c = 0; c < NC; c++) begin
      m_owner[c] <= nown[c];
      m_hold[c]  <= nhold[c];
    end
    m_rr <= nrr;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NC; c++) begin
        m_owner[c] <= -1;
        m_hold[c]  <= 0;
      end
      m_rr <= 0;
    end else begin
      model_step();
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      int eg;
      eg = 0;
      for (int c = 0; c < NC; c++) if (m_owner[c] >= 0) eg |= (1 << m_owner[c]);
      chk("grant", int'(grant), eg);
      for (int c = 0; c < NC; c++) begin
        chk($sformatf("ch_busy[%0d]", c), int'(ch_busy[c]), int'(m_owner[c] >= 0));
        if (m_owner[c] >= 0) begin
          chk($sformatf("ch_owner[%0d]", c), int'(ch_owner[c]), m_owner[c]);
          chk($sformatf("grant_ch[%0d]", m_owner[c]), int'(grant_ch[m_owner[c]]), c);
        end
      end
    end
  end

  logic [NU-1:0] reqv  [8] = '{4'b1111, 4'b1111, 4'b1011, 4'b1111, 4'b0111, 4'b1111, 4'b1111, 4'b1110};
  logic [NU-1:0] lastv [8] = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b1000, 4'b0000};

  initial begin
    reset = 1'b1;
    req   = '0;
    last  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("lit_reset_grant", int'(grant), 0);
    chk("lit_reset_busy", int'(ch_busy), 0);
    chk("lit_reset_owner", int'(ch_owner), 0);

    req = 4'b1111;
    @(negedge clk);
    chk("lit_first_grant", int'(grant), 4'b0011);
    chk("lit_first_owner0", int'(ch_owner[0]), 0);
    chk("lit_first_owner1", int'(ch_owner[1]), 1);

    last = 4'b0001;
    @(negedge clk);
    chk("lit_handover_grant", int'(grant), 4'b0110);
    chk("lit_handover_owner0", int'(ch_owner[0]), 2);
    chk("lit_handover_busy", int'(ch_busy), 2'b11);

    last = 4'b0000;
    req  = 4'b1110;
    repeat (3) @(negedge clk);
    chk("lit_before_preempt", int'(grant), 4'b0110);
    @(negedge clk);
    chk("lit_preempt_grant", int'(grant), 4'b1100);
    chk("lit_preempt_owner1", int'(ch_owner[1]), 3);

    req = 4'b0000;
    @(negedge clk);
    chk("lit_abandon_grant", int'(grant), 0);

    req = 4'b0100;
    @(negedge clk);
    chk("lit_solo_grant", int'(grant), 4'b0100);
    repeat (20) @(negedge clk);
    chk("lit_solo_hold_grant", int'(grant), 4'b0100);
    chk("lit_solo_hold_owner0", int'(ch_owner[0]), 2);

    req = 4'b1101;
    @(negedge clk);
    chk("lit_join_grant", int'(grant), 4'b1100);
    chk("lit_join_busy", int'(ch_busy), 2'b11);
    @(negedge clk);
    chk("lit_frozen_hold_grant", int'(grant), 4'b1100);

    #2 reset = 1'b1;
    #1;
    chk("lit_async_grant", int'(grant), 0);
    chk("lit_async_busy", int'(ch_busy), 0);
    chk("lit_async_owner", int'(ch_owner), 0);
    chk("lit_async_grant_ch", int'(grant_ch), 0);
    @(negedge clk);
    reset = 1'b0;
    req   = 4'b1000;
    @(negedge clk);
    chk("lit_post_reset_grant", int'(grant), 4'b1000);
    chk("lit_post_reset_owner0", int'(ch_owner[0]), 3);
    chk("lit_post_reset_busy", int'(ch_busy), 2'b01);

    for (int i = 0; i < 8; i++) begin
      req  = reqv[i];
      last = lastv[i];
      @(negedge clk);
    end
    last = '0;
    req  = 4'b1111;
    repeat (14) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
